// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port AWxDW data memory between the core
// load/store unit (port 0) and the loader/debug port (port 1).
// Each transaction takes two cycles: grant in IDLE, memory access in ACCESS,
// then a one-cycle done pulse. The block owns the memory write enable and
// drops a port-0 write that repeats the last performed port-0 write pc.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int PCW      = 12,
    parameter int GUARD_EN = 1,
    parameter int FIX_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    // port 0: core load/store unit
    input  logic           r0_req,
    input  logic           r0_we,
    input  logic [AW-1:0]  r0_addr,
    input  logic [DW-1:0]  r0_wdata,
    input  logic [PCW-1:0] r0_pc,
    output logic           r0_gnt,
    output logic           r0_done,
    output logic [DW-1:0]  r0_rdata,
    // port 1: loader / debug port
    input  logic           r1_req,
    input  logic           r1_we,
    input  logic [AW-1:0]  r1_addr,
    input  logic [DW-1:0]  r1_wdata,
    output logic           r1_gnt,
    output logic           r1_done,
    output logic [DW-1:0]  r1_rdata,
    // memory side
    output logic [AW-1:0]  mem_addr,
    output logic           mem_wr_en,
    output logic [DW-1:0]  mem_dat_in,
    input  logic [DW-1:0]  mem_dat_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;

    // transaction captured at grant time, replayed to the memory in ACCESS
    logic           lat_we;
    logic [AW-1:0]  lat_addr;
    logic [DW-1:0]  lat_wdata;
    logic [PCW-1:0] lat_pc;
    logic           lat_win;      // 0 = port 0 owns the access, 1 = port 1

    logic           last_winner;  // port granted most recently
    logic [PCW-1:0] last_pc;      // pc of the last performed port-0 write
    logic           last_pc_valid;

    logic           grant0;
    logic           grant1;
    logic           suppress;
    logic           wr_go;

    // State register; a low rst_n at the edge returns the FSM to IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values no matter how the always_ff blocks are ordered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration and next state: pick at most one winner while IDLE.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                if (r0_req && r1_req) begin
                    // tie: fixed priority favours port 0, otherwise the port
                    // that did not win last time goes next
                    if ((FIX_PRIO != 0) || last_winner) begin
                        grant0 = 1'b1;
                    end else begin
                        grant1 = 1'b1;
                    end
                end else if (r0_req) begin
                    grant0 = 1'b1;
                end else if (r1_req) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                // requests are ignored here; the loser is served next IDLE
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Grants are only meaningful out of reset; a grant seen during reset
    // would never be followed by an access.
    assign r0_gnt = grant0 & rst_n;
    assign r1_gnt = grant1 & rst_n;

    // A port-0 write repeating the last performed write pc is dropped here,
    // so the memory array needs no pc knowledge of its own.
    assign suppress  = (GUARD_EN != 0) && !lat_win && last_pc_valid &&
                       (lat_pc == last_pc);
    assign wr_go     = (state == ACCESS) && lat_we && !suppress;
    // gating with rst_n keeps an access interrupted by reset from writing
    assign mem_wr_en = wr_go & rst_n;
    assign mem_addr   = lat_addr;
    assign mem_dat_in = lat_wdata;

    // Capture the winning request and remember who won for round-robin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_pc      <= '0;
            lat_win     <= 1'b0;
            last_winner <= 1'b1;   // port 0 takes the first tie
        end else if (grant0 || grant1) begin
            lat_we      <= grant1 ? r1_we    : r0_we;
            lat_addr    <= grant1 ? r1_addr  : r0_addr;
            lat_wdata   <= grant1 ? r1_wdata : r0_wdata;
            lat_pc      <= r0_pc;  // only consulted when port 0 owns the access
            lat_win     <= grant1;
            last_winner <= grant1;
        end
    end

    // Complete the access: done pulses, read data capture, write-pc history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_done       <= 1'b0;
            r1_done       <= 1'b0;
            r0_rdata      <= '0;
            r1_rdata      <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
        end else begin
            // done follows every access, including a suppressed write
            r0_done <= (state == ACCESS) && !lat_win;
            r1_done <= (state == ACCESS) &&  lat_win;
            // rdata only changes on a read, so it holds across writes
            if ((state == ACCESS) && !lat_we) begin
                if (lat_win) begin
                    r1_rdata <= mem_dat_out;
                end else begin
                    r0_rdata <= mem_dat_out;
                end
            end
            // only a write that really reached memory arms the guard
            if (wr_go && !lat_win) begin
                last_pc       <= lat_pc;
                last_pc_valid <= 1'b1;
            end
        end
    end

endmodule
